// File: rtl/wb_target_mem_pkg.sv
// wb_target_mem_pkg: shared state type and address helpers for the Wishbone target memory.
package wb_target_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  // Compares the address bits above the memory window against the base.
  function automatic logic range_hit(input logic [63:0] adr, input logic [63:0] base, input int lsb, input int depth_log2);
    return (adr >> (lsb + depth_log2)) == (base >> (lsb + depth_log2));
  endfunction
endpackage

// File: rtl/wb_target_mem_ram.sv
// wb_target_mem_ram: single-port word memory with byte-enable writes and a registered read port.
module wb_target_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [1<<DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk)
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (we && sel[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else if (re) rdata_q <= mem[addr];
  assign rdata = rdata_q;
endmodule

// File: rtl/wb_target_mem.sv
// wb_target_mem: Wishbone classic target with wait states, byte lanes, range error and saturating counters.
module wb_target_mem
  import wb_target_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    WS_WIDTH   = 4,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic [DATA_WIDTH-1:0]   dat_r,
  input  logic                    stb,
  input  logic                    cyc,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  output logic                    ack,
  output logic                    err,
  input  logic [WS_WIDTH-1:0]     wait_cycles,
  output logic [CNT_WIDTH-1:0]    rd_count,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic [CNT_WIDTH-1:0]    err_count
);
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int LSB   = clog2(SEL_W);
  state_t                state_q, state_d;
  logic [WS_WIDTH-1:0]   ws_q, ws_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  we_q, we_d, hit_q, hit_d, ack_q, ack_d, err_q, err_d;
  logic [CNT_WIDTH-1:0]  rd_q, rd_d, wr_q, wr_d, ec_q, ec_d;
  logic                  req, fire;
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c, input logic en);
    return c + CNT_WIDTH'(en && c != '1);
  endfunction
  assign req  = cyc & stb;
  assign fire = (state_q == RESP) & req;
  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    we_d    = we_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: if (req) begin
        ws_d    = wait_cycles;
        idx_d   = adr[LSB +: DEPTH_LOG2];
        sel_d   = sel;
        dat_d   = dat_w;
        we_d    = we;
        hit_d   = range_hit(64'(adr), 64'(BASE_ADDR), LSB, DEPTH_LOG2);
        state_d = wait_cycles != '0 ? WAIT : RESP;
      end
      WAIT: begin
        ws_d    = ws_q - WS_WIDTH'(1);
        state_d = !req ? IDLE : ws_q == WS_WIDTH'(1) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
    ack_d = fire & hit_q;
    err_d = fire & ~hit_q;
    rd_d  = bump(rd_q, fire & hit_q & ~we_q);
    wr_d  = bump(wr_q, fire & hit_q & we_q);
    ec_d  = bump(ec_q, fire & ~hit_q);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ws_q    <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ec_q    <= ec_d;
    end
  wb_target_mem_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk  (clock),
    .rst  (reset),
    .we   (fire & hit_q & we_q),
    .re   (fire & hit_q & ~we_q),
    .addr (idx_q),
    .sel  (sel_q),
    .wdata(dat_q),
    .rdata(dat_r)
  );
  assign ack       = ack_q;
  assign err       = err_q;
  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign err_count = ec_q;
endmodule
